// File: rtl/sram_arbiter.sv
// sram_arbiter: shares a 256Kx16 asynchronous SRAM between a read-only video
// fetch port and a CPU read/write port with byte strobes.
//
// Sequencing: IDLE -> ACCESS (WAIT_CYCLES+1 clocks) -> DONE (1 clock).
// DONE is also an arbitration point, so back-to-back requests chain
// DONE -> ACCESS with no idle gap, giving one access per WAIT_CYCLES+2 clocks.
//
// Optional feature: define SRAM_ARB_STARVE_GUARD_EN to enable the CPU
// starvation guard. Once STARVE_LIMIT video grants have been issued while the
// CPU was waiting, the CPU is forced in at the next arbitration point. With
// the macro undefined, video has strict priority and STARVE_LIMIT is unused.
//
// Handshake: a requester raises *_req and holds its address/data/controls
// stable until its *_ack pulse. The ack is a one-cycle pulse with read data
// valid in that same cycle. A requester that does not want another access
// must drop *_req in the ack cycle, because that cycle's closing edge is an
// arbitration point. Dropping a request mid-access does not abort the cycle.
//
// WE_N timing: SRAM_ADDR and the write data are registered on the rising edge
// that enters ACCESS. The falling edge of WE_N is retimed onto the following
// negative clock edge, so the address has been stable for at least one edge
// before WE_N goes low. WE_N rises on the rising edge that enters DONE, while
// address, byte lanes and write data are still held.

module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,

  // Video fetch port (read only)
  input  logic        vid_req,
  input  logic [17:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_data,

  // CPU port
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_bs,
  input  logic [17:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,

  // SRAM pins
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,

  // Status
  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [2:0] LP_WAIT = WAIT_CYCLES[2:0];

  // Reject out-of-range configurations at elaboration time.
  if (WAIT_CYCLES > 7) begin : g_chk_wait
    $error("sram_arbiter: WAIT_CYCLES must be in 0..7");
  end
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_chk_starve
    $error("sram_arbiter: STARVE_LIMIT must be in 1..15");
  end

  // FSM and sequencing state
  state_t      r_state;
  logic [2:0]  r_wait_cnt;
  logic        r_sel_cpu;
  logic        r_write;

  // Registered SRAM-side outputs
  logic [17:0] r_addr;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_ub_n;
  logic        r_lb_n;
  logic        r_we_n_pos;
  logic        r_we_n_neg;
  logic        r_dq_oe;
  logic [15:0] r_dq_out;

  // Registered requester-side outputs
  logic        r_vid_ack;
  logic        r_cpu_ack;
  logic [15:0] r_vid_data;
  logic [15:0] r_cpu_rdata;
  logic        r_busy;

  // Arbitration results
  logic        w_grant_vid;
  logic        w_grant_cpu;
  logic        w_grant_any;
  logic        w_grant_write;
  logic        w_last_access;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LP_STARVE = STARVE_LIMIT[3:0];

  logic [3:0]  r_starve_cnt;
  logic        w_force_cpu;

  assign w_force_cpu = cpu_req && (r_starve_cnt == LP_STARVE);

  // Pick the winner: video first, unless the CPU has waited out its limit.
  always_comb begin
    w_grant_vid = 1'b0;
    w_grant_cpu = 1'b0;
    if (w_force_cpu) begin
      w_grant_cpu = 1'b1;
    end else if (vid_req) begin
      w_grant_vid = 1'b1;
    end else if (cpu_req) begin
      w_grant_cpu = 1'b1;
    end
  end

  // Count video grants issued while the CPU is kept waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= 4'd0;
    end else if (r_state != ST_ACCESS) begin
      if (!cpu_req || w_grant_cpu) begin
        r_starve_cnt <= 4'd0;
      end else if (w_grant_vid) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end
`else
  // Pick the winner: strict video priority.
  always_comb begin
    w_grant_vid = 1'b0;
    w_grant_cpu = 1'b0;
    if (vid_req) begin
      w_grant_vid = 1'b1;
    end else if (cpu_req) begin
      w_grant_cpu = 1'b1;
    end
  end
`endif

  assign w_grant_any   = w_grant_vid | w_grant_cpu;
  assign w_grant_write = w_grant_cpu & cpu_we;
  assign w_last_access = (r_wait_cnt == LP_WAIT);

  // Main sequencer: arbitration, SRAM strobes, read capture and acks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= 3'd0;
      r_sel_cpu   <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= 18'd0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_lb_n      <= 1'b1;
      r_we_n_pos  <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= 16'd0;
      r_vid_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_vid_data  <= 16'd0;
      r_cpu_rdata <= 16'd0;
      r_busy      <= 1'b0;
    end else begin
      r_vid_ack <= 1'b0;
      r_cpu_ack <= 1'b0;

      case (r_state)
        ST_IDLE, ST_DONE: begin
          // Write data held through DONE is released here unless the next
          // winner is itself a write.
          r_dq_oe <= 1'b0;
          if (w_grant_any) begin
            r_state    <= ST_ACCESS;
            r_wait_cnt <= 3'd0;
            r_sel_cpu  <= w_grant_cpu;
            r_write    <= w_grant_write;
            r_addr     <= w_grant_cpu ? cpu_addr : vid_addr;
            r_ce_n     <= 1'b0;
            r_busy     <= 1'b1;
            r_dq_out   <= cpu_wdata;
            r_dq_oe    <= w_grant_write;
            r_we_n_pos <= ~w_grant_write;
            if (w_grant_write) begin
              r_oe_n <= 1'b1;
              r_ub_n <= ~cpu_bs[1];
              r_lb_n <= ~cpu_bs[0];
            end else begin
              r_oe_n <= 1'b0;
              r_ub_n <= 1'b0;
              r_lb_n <= 1'b0;
            end
          end else begin
            r_state    <= ST_IDLE;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_ub_n     <= 1'b1;
            r_lb_n     <= 1'b1;
            r_we_n_pos <= 1'b1;
            r_busy     <= 1'b0;
          end
        end

        ST_ACCESS: begin
          if (w_last_access) begin
            // Final access edge: close the strobes, capture, and ack.
            r_state    <= ST_DONE;
            r_oe_n     <= 1'b1;
            r_we_n_pos <= 1'b1;
            if (r_sel_cpu) begin
              r_cpu_ack <= 1'b1;
              if (!r_write) begin
                r_cpu_rdata <= SRAM_DQ;
              end
            end else begin
              r_vid_ack  <= 1'b1;
              r_vid_data <= SRAM_DQ;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Delay the falling edge of WE_N by half a clock for address setup.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we_n_neg <= 1'b1;
    end else begin
      r_we_n_neg <= r_we_n_pos;
    end
  end

  // WE_N is low only while both phases agree; the rise follows r_we_n_pos
  // directly, the fall waits for r_we_n_neg.
  assign SRAM_WE_N   = r_we_n_pos | r_we_n_neg;

  assign SRAM_DQ     = r_dq_oe ? r_dq_out : 16'hzzzz;
  assign SRAM_ADDR   = r_addr;
  assign SRAM_CE_N   = r_ce_n;
  assign SRAM_OE_N   = r_oe_n;
  assign SRAM_UB_N   = r_ub_n;
  assign SRAM_LB_N   = r_lb_n;

  assign vid_ack     = r_vid_ack;
  assign vid_data    = r_vid_data;
  assign cpu_ack     = r_cpu_ack;
  assign cpu_rdata   = r_cpu_rdata;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural async SRAM model, table of CPU
// transactions, and hand-written collision / starvation / reset sequences.

module tb_sram_arbiter;

  localparam int W   = 1;
  localparam int SL  = 4;
  localparam int LAT = W + 2;

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT connections
  logic        vid_req = 1'b0;
  logic [17:0] vid_addr = 18'd0;
  logic        vid_ack;
  logic [15:0] vid_data;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_bs = 2'b00;
  logic [17:0] cpu_addr = 18'd0;
  logic [15:0] cpu_wdata = 16'd0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;
  logic        busy;
  logic [1:0]  dbg_state;

  sram_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset_n(reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bs(cpu_bs), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n), .SRAM_WE_N(sram_we_n), .SRAM_CE_N(sram_ce_n),
    .SRAM_OE_N(sram_oe_n), .busy(busy), .o_dbg_state(dbg_state)
  );

  // Asynchronous SRAM model: drives on read, latches lanes on WE_N rise.
  logic [15:0] mem [0:262143];
  logic [15:0] mem_rd;
  assign mem_rd  = mem[sram_addr];
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem_rd : 16'hzzzz;
  wire dq_z = (sram_dq === 16'hzzzz);

  always @(posedge sram_we_n) begin
    if (reset_n && !sram_ce_n) begin
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
      if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
    end
  end

  // Scoreboard
  logic [15:0] exp_q[$];
  logic [15:0] vid_exp_q[$];
  logic [15:0] exp_cpu_rdata = 16'd0;
  int checks = 0;
  int errors = 0;
  int step = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, step, act, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [1:0]  bs;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  // One CPU transaction from an idle DUT, with strobe and latency checks.
  task automatic cpu_op(input vec_t v);
    int n;
    bit got;
    logic [15:0] e;
    cpu_we = v.we; cpu_bs = v.bs; cpu_addr = v.addr; cpu_wdata = v.wdata;
    cpu_req = 1'b1;
    if (!v.we) exp_q.push_back(v.exp);
    n = 0; got = 1'b0;
    while (!got && n < 50) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        check("access_ce_n", sram_ce_n, 0);
        check("access_addr", sram_addr, v.addr);
        check("access_busy", busy, 1);
        if (v.we) begin
          check("wr_oe_n", sram_oe_n, 1);
          check("wr_ub_n", sram_ub_n, !v.bs[1]);
          check("wr_lb_n", sram_lb_n, !v.bs[0]);
          check("wr_we_n_setup", sram_we_n, 1);
          @(negedge clk); #1;
          check("wr_we_n_low", sram_we_n, 0);
          check("wr_dq", sram_dq, v.wdata);
        end else begin
          check("rd_oe_n", sram_oe_n, 0);
          check("rd_lanes", {sram_ub_n, sram_lb_n}, 2'b00);
          check("rd_we_n", sram_we_n, 1);
        end
      end
      if (cpu_ack) got = 1'b1;
    end
    cpu_req = 1'b0;
    check("cpu_ack_latency", n, LAT);
    if (got) begin
      check("done_oe_we", {sram_oe_n, sram_we_n}, 2'b11);
      if (v.we) begin
        check("done_dq_hold", sram_dq, v.wdata);
        check("wr_rdata_hold", cpu_rdata, exp_cpu_rdata);
      end else begin
        check("rd_turnaround_z", dq_z, 1);
        e = exp_q.pop_front();
        check("cpu_rdata", cpu_rdata, e);
        exp_cpu_rdata = e;
      end
    end else if (!v.we) begin
      void'(exp_q.pop_front());
    end
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_ce_n", sram_ce_n, 1);
    check("idle_dq_z", dq_z, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we_n"}, sram_we_n, 1);
    check({tag, "_ce_oe_n"}, {sram_ce_n, sram_oe_n}, 2'b11);
    check({tag, "_lanes"}, {sram_ub_n, sram_lb_n}, 2'b11);
    check({tag, "_dq_z"}, dq_z, 1);
    check({tag, "_addr"}, sram_addr, 0);
    check({tag, "_acks"}, {vid_ack, cpu_ack}, 2'b00);
    check({tag, "_data"}, {vid_data, cpu_rdata}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n, vn, cn, nv, nc, prev, cpu_pos, m, acks;
    logic [15:0] e;

    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;

    vecs[0]  = '{we:1'b1, bs:2'b11, addr:18'h12345, wdata:16'hBEEF, exp:16'h0000};
    vecs[1]  = '{we:1'b0, bs:2'b00, addr:18'h12345, wdata:16'h0000, exp:16'hBEEF};
    vecs[2]  = '{we:1'b1, bs:2'b11, addr:18'h00100, wdata:16'h1111, exp:16'h0000};
    vecs[3]  = '{we:1'b1, bs:2'b01, addr:18'h00100, wdata:16'hAA55, exp:16'h0000};
    vecs[4]  = '{we:1'b0, bs:2'b11, addr:18'h00100, wdata:16'h0000, exp:16'h1155};
    vecs[5]  = '{we:1'b1, bs:2'b00, addr:18'h00100, wdata:16'hFFFF, exp:16'h0000};
    vecs[6]  = '{we:1'b0, bs:2'b00, addr:18'h00100, wdata:16'h0000, exp:16'h1155};
    vecs[7]  = '{we:1'b1, bs:2'b10, addr:18'h00100, wdata:16'h7700, exp:16'h0000};
    vecs[8]  = '{we:1'b0, bs:2'b00, addr:18'h00100, wdata:16'h0000, exp:16'h7755};
    vecs[9]  = '{we:1'b1, bs:2'b11, addr:18'h3FFFF, wdata:16'hCAFE, exp:16'h0000};
    vecs[10] = '{we:1'b0, bs:2'b00, addr:18'h3FFFF, wdata:16'h0000, exp:16'hCAFE};
    vecs[11] = '{we:1'b0, bs:2'b00, addr:18'h00000, wdata:16'h0000, exp:16'h0000};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven CPU transactions
    for (int i = 0; i < 12; i++) begin
      step = i;
      cpu_op(vecs[i]);
    end

    // Collision: video wins, CPU chains from DONE with no idle gap
    step = 100;
    vid_addr = 18'h12345; vid_req = 1'b1;
    cpu_addr = 18'h00100; cpu_we = 1'b0; cpu_bs = 2'b00; cpu_req = 1'b1;
    vid_exp_q.push_back(16'hBEEF);
    exp_q.push_back(16'h7755);
    n = 0; vn = 0; cn = 0;
    while ((vn == 0 || cn == 0) && n < 40) begin
      @(posedge clk); #1; n++;
      check("coll_busy", busy, 1);
      if (vid_ack) begin
        vn = n; vid_req = 1'b0;
        e = vid_exp_q.pop_front();
        check("coll_vid_data", vid_data, e);
      end
      if (cpu_ack) begin
        cn = n; cpu_req = 1'b0;
        e = exp_q.pop_front();
        check("coll_cpu_rdata", cpu_rdata, e);
        exp_cpu_rdata = e;
        check("coll_vid_data_hold", vid_data, 16'hBEEF);
      end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    check("coll_vid_latency", vn, LAT);
    check("coll_cpu_latency", cn, 2 * LAT);
    vid_exp_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;

    // Starvation: video held high, CPU waiting
    step = 200;
    vid_addr = 18'h3FFFF; vid_req = 1'b1;
    cpu_addr = 18'h12345; cpu_we = 1'b0; cpu_req = 1'b1;
    exp_q.push_back(16'hBEEF);
    n = 0; nv = 0; nc = 0; prev = 0; cpu_pos = -1;
    while ((nv + nc) < 6 && n < 100) begin
      @(posedge clk); #1; n++;
      if (vid_ack || cpu_ack) begin
        check("starve_ack_spacing", n - prev, LAT);
        prev = n;
      end
      if (vid_ack) begin
        nv++;
        check("starve_vid_data", vid_data, 16'hCAFE);
        if ((nv + nc) == 6) vid_req = 1'b0;
      end
      if (cpu_ack) begin
        nc++; cpu_pos = nv; cpu_req = 1'b0;
        e = exp_q.pop_front();
        check("starve_cpu_rdata", cpu_rdata, e);
        exp_cpu_rdata = e;
      end
    end
    vid_req = 1'b0;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    check("starve_cpu_after_limit", cpu_pos, SL);
    check("starve_cpu_acks", nc, 1);
    check("starve_vid_resumed", nv, 5);
`else
    check("strict_no_cpu_ack", nc, 0);
    check("strict_vid_acks", nv, 6);
    m = 0; cn = 0;
    while (cn == 0 && m < 40) begin
      @(posedge clk); #1; m++;
      if (cpu_ack) begin
        cn = 1; cpu_req = 1'b0;
        e = exp_q.pop_front();
        check("strict_cpu_rdata", cpu_rdata, e);
        exp_cpu_rdata = e;
      end
    end
    check("strict_cpu_latency", m, LAT);
`endif
    cpu_req = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a write access
    step = 300;
    cpu_addr = 18'h00200; cpu_we = 1'b1; cpu_bs = 2'b11; cpu_wdata = 16'h1234;
    cpu_req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("mid_we_n_low", sram_we_n, 0);
    check("mid_dq_driven", sram_dq, 16'h1234);
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    cpu_req = 1'b0;
    exp_cpu_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (vid_ack || cpu_ack) acks++;
    end
    check("mid_no_ack_after_release", acks, 0);
    check("mid_idle_state", dbg_state, 0);

    // Recovery: a read after the aborted write still works
    step = 400;
    cpu_op('{we:1'b0, bs:2'b00, addr:18'h12345, wdata:16'h0000, exp:16'hBEEF});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
